// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // One slot of the response shift register. dat holds the raw array word,
  // or zero for stores and error accesses so the read-side extension yields 0.
  typedef struct packed {
    logic        vld;
    logic        err;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] dat;
  } rsp_stage_t;

  // Size 2'b11 has no legal alignment, so it is reported here as well and
  // the caller needs a single error term.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables + lane replication, load lane select + extension.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: size/offset/is_unsigned describe the access; wdata -> byte_en/wdata_lane
// is the store path; rdata_word -> rdata_ext is the load path.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    byte_en    = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    // Bring the addressed lane down to bit 0 before extending.
    shifted    = rdata_word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byte_en    = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_word;
      end
      default: begin
        byte_en    = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed RV32 data memory with LB/LH/LW/LBU/LHU/SB/SH/SW and misalign detection.
// Latency: response READ_LATENCY cycles after acceptance, fully pipelined, in order.
// Backpressure: req_ready low only during the power-up clear; responses cannot stall.
//
// Ports: CLK/RESET_N; request req_valid/req_ready/req_we/req_addr(byte)/req_size/
// req_unsigned/req_wdata; response rsp_valid/rsp_rdata/rsp_err (one pulse per request).
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH != 32) begin : g_dw_check
    $error("dmem_lsu: DATA_WIDTH must be 32");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_rl_check
    $error("dmem_lsu: READ_LATENCY must be 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [3:0]            wr_be;
  logic [31:0]           wr_lane;
  rsp_stage_t            stage_in;
  rsp_stage_t            pipe_q [READ_LATENCY];
  rsp_stage_t            pipe_out;
  logic [31:0]           rd_ext;

  logic [31:0]           unused_wr_rdata;
  logic [3:0]            unused_rd_be;
  logic [31:0]           unused_rd_lane;

  // ---------------- clear FSM ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= (INIT_ZERO != 0) ? INIT : RUN;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      INIT: if (&init_cnt_q) state_d = RUN;   // last word cleared this cycle
      RUN:  req_ready = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // ---------------- request side ----------------
  assign accept    = req_valid & req_ready;
  assign req_err   = misaligned(req_size, req_addr[1:0]);
  assign word_addr = req_addr[ADDR_WIDTH+1:2];

  dmem_lane_align u_wr_align (
    .size        (req_size),
    .offset      (req_addr[1:0]),
    .is_unsigned (1'b0),
    .wdata       (req_wdata),
    .rdata_word  (32'd0),
    .byte_en     (wr_be),
    .wdata_lane  (wr_lane),
    .rdata_ext   (unused_wr_rdata)
  );

  // Array has no reset: contents survive RESET_N when the clear is disabled.
  always_ff @(posedge CLK) begin
    if (state_q == INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_addr][8*b +: 8] <= wr_lane[8*b +: 8];
      end
    end
  end

  // The array is sampled at the acceptance edge, so a store committed one
  // edge earlier is already visible to a following load.
  always_comb begin
    stage_in      = '0;
    stage_in.vld  = accept;
    stage_in.err  = req_err;
    stage_in.off  = req_addr[1:0];
    stage_in.size = req_size;
    stage_in.uns  = req_unsigned;
    if (accept && !req_we && !req_err) stage_in.dat = mem[word_addr];
  end

  // ---------------- response pipeline ----------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out = pipe_q[READ_LATENCY-1];

  dmem_lane_align u_rd_align (
    .size        (pipe_out.size),
    .offset      (pipe_out.off),
    .is_unsigned (pipe_out.uns),
    .wdata       (32'd0),
    .rdata_word  (pipe_out.dat),
    .byte_en     (unused_rd_be),
    .wdata_lane  (unused_rd_lane),
    .rdata_ext   (rd_ext)
  );

  assign rsp_valid = pipe_out.vld;
  assign rsp_err   = pipe_out.vld & pipe_out.err;
  assign rsp_rdata = pipe_out.vld ? rd_ext : '0;

endmodule
